// File: rtl/puf_challenge_sequencer.sv
// RO-PUF challenge sequencer: steps a latched 16-bit challenge one bit per round and
// drives the round/count timing bus, RO enables and strobes for the response register.
module puf_challenge_sequencer #(
    parameter int ROUNDS     = 16,
    parameter int SAMPLE_CNT = 25,
    parameter int IDLE_CNT   = 31
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        chal_valid,
    output logic        chal_ready,
    input  logic [15:0] challenge,
    input  logic        abort,
    output logic [3:0]  round,
    output logic [4:0]  count,
    output logic        ro_sel,
    output logic        ro_en,
    output logic        ro_clr,
    output logic        sample,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_n;
    logic [15:0] chal_q, chal_n;
    logic [3:0]  round_n;
    logic [4:0]  count_n;
    logic        chal_ready_n, ro_sel_n, ro_en_n, ro_clr_n, sample_n, busy_n, done_n;

    // Every output is registered: this block computes the values they take after the edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it
        // unassigned; an unassigned path would infer a latch.
        state_n      = state;
        chal_n       = chal_q;
        round_n      = '0;
        count_n      = 5'(IDLE_CNT);
        chal_ready_n = 1'b0;
        ro_sel_n     = 1'b0;
        ro_en_n      = 1'b0;
        ro_clr_n     = 1'b0;
        sample_n     = 1'b0;
        busy_n       = 1'b0;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                if (chal_valid && chal_ready) begin
                    chal_n  = challenge;
                    state_n = RUN;
                    count_n = '0;
                end else begin
                    chal_ready_n = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n      = IDLE;
                    chal_ready_n = 1'b1;
                end else if (count == 5'(SAMPLE_CNT)) begin
                    // Last round ends in DONE rather than wrapping the round counter.
                    if (round == 4'(ROUNDS - 1)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        round_n = round + 4'd1;
                        count_n = '0;
                    end
                end else begin
                    round_n = round;
                    count_n = count + 5'd1;
                end
            end
            DONE: begin
                state_n      = IDLE;
                chal_ready_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (state_n == RUN) begin
            busy_n   = 1'b1;
            ro_en_n  = 1'b1;
            ro_sel_n = chal_n[round_n];
            ro_clr_n = (count_n == 5'd0);
            sample_n = (count_n == 5'(SAMPLE_CNT));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the
        // pre-edge values, independent of statement order.
        if (!Reset_n) begin
            state      <= IDLE;
            chal_q     <= '0;
            round      <= '0;
            count      <= 5'(IDLE_CNT);
            chal_ready <= 1'b1;
            ro_sel     <= 1'b0;
            ro_en      <= 1'b0;
            ro_clr     <= 1'b0;
            sample     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            chal_q     <= chal_n;
            round      <= round_n;
            count      <= count_n;
            chal_ready <= chal_ready_n;
            ro_sel     <= ro_sel_n;
            ro_en      <= ro_en_n;
            ro_clr     <= ro_clr_n;
            sample     <= sample_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer: directed table, hand-written corner
// sequences and a randomized run, all compared against a cycle-offset reference model.
module tb_puf_challenge_sequencer;

    logic        clk = 1'b0;
    logic        Reset_n, chal_valid, abort;
    logic [15:0] challenge;
    logic        chal_ready, ro_sel, ro_en, ro_clr, sample, busy, done;
    logic [3:0]  round;
    logic [4:0]  count;

    always #5 clk = ~clk;

    puf_challenge_sequencer dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .chal_valid(chal_valid),
        .chal_ready(chal_ready),
        .challenge (challenge),
        .abort     (abort),
        .round     (round),
        .count     (count),
        .ro_sel    (ro_sel),
        .ro_en     (ro_en),
        .ro_clr    (ro_clr),
        .sample    (sample),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output bundle: {ready, busy, done, en, clr, sample, sel, round[3:0], count[4:0]}
    function automatic logic [15:0] out_vec();
        return {chal_ready, busy, done, ro_en, ro_clr, sample, ro_sel, round, count};
    endfunction

    // Reference model: rc = cycles since acceptance (0 idle, 1..416 running, 417 done).
    int          rc     = 0;
    logic [15:0] m_chal = '0;

    function automatic logic [15:0] exp_vec();
        int         n;
        logic [3:0] r;
        logic [4:0] c;
        if (rc == 0)   return {7'b1000000, 4'd0, 5'd31};
        if (rc == 417) return {7'b0010000, 4'd0, 5'd31};
        n = rc - 1;
        r = 4'(n / 26);
        c = 5'(n % 26);
        return {1'b0, 1'b1, 1'b0, 1'b1, c == 5'd0, c == 5'd25, m_chal[r], r, c};
    endfunction

    task automatic tick();
        if (!Reset_n) begin
            rc = 0; m_chal = '0;
        end else if (rc == 0) begin
            if (chal_valid) begin m_chal = challenge; rc = 1; end
        end else if (rc <= 416) begin
            rc = abort ? 0 : rc + 1;
        end else begin
            rc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string name);
        tick();
        check(name, {16'd0, out_vec()}, {16'd0, exp_vec()});
    endtask

    // Stand-in response register fed a known comparator pattern, plus an ro_sel logger.
    logic [15:0] cmp_pat = 16'h3C5A;
    logic [15:0] resp, sel_seq;
    always @(posedge clk) begin
        if (ro_clr && round == 4'd0) resp <= '0;
        else if (sample)             resp[round] <= cmp_pat[round];
        if (sample) sel_seq[round] <= ro_sel;
    end

    typedef struct {
        logic        rst_n, valid, abrt;
        logic [15:0] chal;
        int          cycles;
        logic        rdy, bsy, dn, en, clr, smp, sel;
        logic [3:0]  rnd;
        logic [4:0]  cnt;
        string       name;
    } vec_t;

    vec_t vecs[8];

    initial begin
        Reset_n = 1'b0; chal_valid = 1'b0; abort = 1'b0; challenge = '0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2,   1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd31, "reset"};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 3,   1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd31, "idle_abort_ignored"};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'hA5C3, 1,   0, 1, 0, 1, 1, 0, 1, 4'd0, 5'd0,  "accept"};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 25,  0, 1, 0, 1, 0, 1, 1, 4'd0, 5'd25, "first_sample"};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1,   0, 1, 0, 1, 1, 0, 1, 4'd1, 5'd0,  "count_wrap"};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 166, 0, 1, 0, 1, 0, 0, 1, 4'd7, 5'd10, "round7_cnt10"};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1,   1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd31, "abort_to_idle"};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1,   1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd31, "idle_no_done"};

        for (int i = 0; i < 8; i++) begin
            Reset_n = vecs[i].rst_n; chal_valid = vecs[i].valid;
            abort = vecs[i].abrt;    challenge = vecs[i].chal;
            repeat (vecs[i].cycles) tick();
            check(vecs[i].name, {16'd0, out_vec()},
                  {16'd0, vecs[i].rdy, vecs[i].bsy, vecs[i].dn, vecs[i].en, vecs[i].clr,
                   vecs[i].smp, vecs[i].sel, vecs[i].rnd, vecs[i].cnt});
        end

        // Full run with A5C3 while a second word is held valid; it must wait for IDLE.
        Reset_n = 1'b0; tick(); Reset_n = 1'b1;
        chal_valid = 1'b1; challenge = 16'hA5C3;
        tick_chk("run1_accept");
        challenge = 16'h1234;
        for (int i = 0; i < 416; i++) tick_chk("run1_cycle");
        check("run1_done_pulse", {31'd0, done}, 32'd1);
        check("run1_resp", {16'd0, resp}, {16'd0, cmp_pat});
        check("run1_sel_seq", {16'd0, sel_seq}, 32'h0000A5C3);
        tick_chk("run1_back_idle");
        for (int i = 0; i < 418; i++) tick_chk("run2_cycle");
        check("run2_sel_seq", {16'd0, sel_seq}, 32'h00001234);
        chal_valid = 1'b0;
        tick_chk("run2_idle");

        // Reset together with abort at round 3, count 25.
        chal_valid = 1'b1; challenge = 16'hBEEF;
        tick_chk("run3_accept");
        chal_valid = 1'b0;
        repeat (103) tick();
        check("run3_at_r3c25", {16'd0, out_vec()}, {16'd0, 7'b0101011, 4'd3, 5'd25});
        Reset_n = 1'b0; abort = 1'b1;
        tick_chk("reset_over_abort");
        Reset_n = 1'b1; abort = 1'b0;
        tick_chk("after_reset_idle");

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            Reset_n    = ($urandom_range(0, 999) != 0);
            chal_valid = ($urandom_range(0, 3) == 0);
            abort      = ($urandom_range(0, 149) == 0);
            challenge  = 16'($urandom);
            tick_chk("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
